// File: rtl/bayer_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bayer_stream_gen                                              |
// | Purpose  : Converts an RGB pixel stream into a raw Bayer sample stream   |
// |            with a selectable CFA order. Frames start with a lead-in,     |
// |            every row (active or flush) is followed by horizontal         |
// |            blanking, and zero-data flush rows are appended after the     |
// |            last active row so downstream pipelines drain on their own.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   clock                                                  |
// |   reset      in   asynchronous active-low reset                          |
// |   iStart     in   start-of-frame request (honoured only when idle)       |
// |   iValid     in   input pixel valid                                      |
// |   iR/iG/iB   in   colour samples, DATA_W bits each                       |
// |   iPattern   in   runtime CFA order (only with BAYER_RUNTIME_PATTERN_EN) |
// |   oReady     out  pixel accepted this cycle when iValid is also high     |
// |   oNewFrame  out  one-cycle frame-start pulse                            |
// |   oValid     out  oData / oRow / oCol valid                              |
// |   oData      out  raw Bayer sample                                       |
// |   oRow/oCol  out  position of the current sample                         |
// |   oBusy      out  frame in progress                                      |
// |   oDone      out  one-cycle end-of-frame pulse                           |
// | Build option                                                             |
// |   BAYER_RUNTIME_PATTERN_EN : adds iPattern, latched at frame start;      |
// |                              PATTERN becomes its reset value.            |
// | CFA order : 0=GBRG 1=GRBG 2=RGGB 3=BGGR                                  |
// +--------------------------------------------------------------------------+
module bayer_stream_gen #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int DATA_W     = 8,
   parameter int SOF_LEAD   = 32,
   parameter int HBLANK     = 16,
   parameter int FLUSH_ROWS = 2,
   parameter int PATTERN    = 0,
   localparam int ROW_W = ($clog2(HEIGHT + FLUSH_ROWS) > 0) ? $clog2(HEIGHT + FLUSH_ROWS) : 1,
   localparam int COL_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iStart,
   input  logic              iValid,
   input  logic [DATA_W-1:0] iR,
   input  logic [DATA_W-1:0] iG,
   input  logic [DATA_W-1:0] iB,
`ifdef BAYER_RUNTIME_PATTERN_EN
   input  logic [1:0]        iPattern,
`endif
   output logic              oReady,
   output logic              oNewFrame,
   output logic              oValid,
   output logic [DATA_W-1:0] oData,
   output logic [ROW_W-1:0]  oRow,
   output logic [COL_W-1:0]  oCol,
   output logic              oBusy,
   output logic              oDone
);

   // Internal row counter must be able to hold HEIGHT+FLUSH_ROWS (end marker).
   localparam int ROWC_W = $clog2(HEIGHT + FLUSH_ROWS + 1);
   localparam int LEAD_W = ($clog2(SOF_LEAD + 1) > 0) ? $clog2(SOF_LEAD + 1) : 1;
   localparam int BLK_W  = ($clog2(HBLANK + 1) > 0) ? $clog2(HBLANK + 1) : 1;

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
   localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(SOF_LEAD - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [ROWC_W-1:0] ROW_ACT   = ROWC_W'(HEIGHT);
   localparam logic [ROWC_W-1:0] ROW_END   = ROWC_W'(HEIGHT + FLUSH_ROWS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEAD   = 3'd1,
      S_ACTIVE = 3'd2,
      S_HBLANK = 3'd3,
      S_FLUSH  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [LEAD_W-1:0]   lead_q, lead_d;
   logic [BLK_W-1:0]    blank_q, blank_d;
   logic [ROWC_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;

   logic                ready_q, ready_d;
   logic                newframe_q, newframe_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ROW_W-1:0]    orow_q, orow_d;
   logic [COL_W-1:0]    ocol_q, ocol_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [1:0]          pattern;
   logic                xfer;
   logic [ROWC_W-1:0]   row_inc;

   // ---------------------------------------------------------------------
   // CFA order source
   // ---------------------------------------------------------------------
`ifdef BAYER_RUNTIME_PATTERN_EN
   logic [1:0] pattern_q;

   // Latched on the IDLE->LEAD transition so mid-frame changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern_q <= 2'(PATTERN);
      end else if (state_q == S_IDLE && iStart) begin
         pattern_q <= iPattern;
      end
   end

   assign pattern = pattern_q;
`else
   assign pattern = 2'(PATTERN);
`endif

   // ---------------------------------------------------------------------
   // Colour select: green sits where row and column parity differ for
   // RGGB/BGGR and where they match for GBRG/GRBG. Red shares the odd rows
   // for GBRG/BGGR and the even rows for GRBG/RGGB; blue takes the rest.
   // ---------------------------------------------------------------------
   logic              rc_diff, is_green, red_on_odd, is_red;
   logic [DATA_W-1:0] sample;

   always_comb begin
      rc_diff    = row_q[0] ^ col_q[0];
      is_green   = pattern[1] ? rc_diff : ~rc_diff;
      red_on_odd = (pattern == 2'd0) || (pattern == 2'd3);
      is_red     = red_on_odd ? row_q[0] : ~row_q[0];
      if (is_green) begin
         sample = iG;
      end else if (is_red) begin
         sample = iR;
      end else begin
         sample = iB;
      end
   end

   // State reached once a row's blanking has finished (or immediately at
   // the end of a row when there is no blanking).
   function automatic state_t after_blank(input logic [ROWC_W-1:0] r);
      if (r < ROW_ACT) begin
         return S_ACTIVE;
      end else if (r < ROW_END) begin
         return S_FLUSH;
      end else begin
         return S_DONE;
      end
   endfunction

   function automatic state_t after_row(input logic [ROWC_W-1:0] r);
      if (HBLANK > 0) begin
         return S_HBLANK;
      end else begin
         return after_blank(r);
      end
   endfunction

   assign row_inc = row_q + ROWC_W'(1);
   // ready_q is high exactly while the FSM sits in ACTIVE.
   assign xfer    = ready_q && iValid;

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      lead_d     = lead_q;
      blank_d    = blank_q;
      row_d      = row_q;
      col_d      = col_q;
      newframe_d = 1'b0;
      valid_d    = 1'b0;
      data_d     = data_q;
      orow_d     = orow_q;
      ocol_d     = ocol_q;

      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               state_d    = S_LEAD;
               lead_d     = '0;
               row_d      = '0;
               col_d      = '0;
               newframe_d = 1'b1;
            end
         end
         S_LEAD: begin
            if (lead_q == LEAD_LAST) begin
               state_d = S_ACTIVE;
               row_d   = '0;
               col_d   = '0;
            end else begin
               lead_d = lead_q + LEAD_W'(1);
            end
         end
         S_ACTIVE: begin
            if (xfer) begin
               valid_d = 1'b1;
               data_d  = sample;
               orow_d  = row_q[ROW_W-1:0];
               ocol_d  = col_q;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  row_d   = row_inc;
                  blank_d = '0;
                  state_d = after_row(row_inc);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         S_HBLANK: begin
            if (blank_q == BLK_LAST) begin
               state_d = after_blank(row_q);
            end else begin
               blank_d = blank_q + BLK_W'(1);
            end
         end
         S_FLUSH: begin
            valid_d = 1'b1;
            data_d  = '0;
            orow_d  = row_q[ROW_W-1:0];
            ocol_d  = col_q;
            if (col_q == COL_LAST) begin
               col_d   = '0;
               row_d   = row_inc;
               blank_d = '0;
               state_d = after_row(row_inc);
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they line up with
      // the state they describe once registered.
      ready_d = (state_d == S_ACTIVE);
      busy_d  = (state_d == S_LEAD) || (state_d == S_ACTIVE) ||
                (state_d == S_HBLANK) || (state_d == S_FLUSH);
      done_d  = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         lead_q     <= '0;
         blank_q    <= '0;
         row_q      <= '0;
         col_q      <= '0;
         ready_q    <= 1'b0;
         newframe_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lead_q     <= lead_d;
         blank_q    <= blank_d;
         row_q      <= row_d;
         col_q      <= col_d;
         ready_q    <= ready_d;
         newframe_q <= newframe_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         orow_q     <= orow_d;
         ocol_q     <= ocol_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign oReady    = ready_q;
   assign oNewFrame = newframe_q;
   assign oValid    = valid_q;
   assign oData     = data_q;
   assign oRow      = orow_q;
   assign oCol      = ocol_q;
   assign oBusy     = busy_q;
   assign oDone     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bayer_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bayer_stream_gen                                           |
// | Purpose  : Directed self-checking bench for bayer_stream_gen. Two        |
// |            instances (GBRG and BGGR) with a 4x2 frame, 3-cycle lead-in,  |
// |            2-cycle blanking and one flush row.                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bayer_stream_gen;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int DW  = 8;
   localparam int LD  = 3;
   localparam int HB  = 2;
   localparam int FR  = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          startA, startB, iValid;
   logic [DW-1:0] iR, iG, iB;
`ifdef BAYER_RUNTIME_PATTERN_EN
   logic [1:0]    patA, patB;
`endif

   logic          readyA, nfA, validA, busyA, doneA;
   logic [DW-1:0] dataA;
   logic [1:0]    rowA, colA;
   logic          readyB, nfB, validB, busyB, doneB;
   logic [DW-1:0] dataB;
   logic [1:0]    rowB, colB;

   always #5 clk = ~clk;

   bayer_stream_gen #(
      .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .SOF_LEAD(LD),
      .HBLANK(HB), .FLUSH_ROWS(FR), .PATTERN(0)
   ) dut_a (
      .clk(clk), .reset(reset), .iStart(startA), .iValid(iValid),
      .iR(iR), .iG(iG), .iB(iB),
`ifdef BAYER_RUNTIME_PATTERN_EN
      .iPattern(patA),
`endif
      .oReady(readyA), .oNewFrame(nfA), .oValid(validA), .oData(dataA),
      .oRow(rowA), .oCol(colA), .oBusy(busyA), .oDone(doneA)
   );

   bayer_stream_gen #(
      .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .SOF_LEAD(LD),
      .HBLANK(HB), .FLUSH_ROWS(FR), .PATTERN(3)
   ) dut_b (
      .clk(clk), .reset(reset), .iStart(startB), .iValid(iValid),
      .iR(iR), .iG(iG), .iB(iB),
`ifdef BAYER_RUNTIME_PATTERN_EN
      .iPattern(patB),
`endif
      .oReady(readyB), .oNewFrame(nfB), .oValid(validB), .oData(dataB),
      .oRow(rowB), .oCol(colB), .oBusy(busyB), .oDone(doneB)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Observations of one frame
   int            nf_cnt, nf_cyc, first_ready, done_cnt, done_cyc;
   logic [DW-1:0] rd[$];
   int            rrow[$], rcol[$], rcyc[$];
   logic          busy_log[64];

   int   k;
   logic pend;
   logic sel_b;

   // One cycle: outputs are observed 1 time unit after the rising edge, then
   // inputs for the next edge are driven. Pixel k carries R=k, G=0x40+k,
   // B=0x80+k and advances only after an actual transfer.
   task automatic tick(input logic v, input logic s);
      @(posedge clk);
      #1;
      if (pend) k++;
      iValid = v;
      startA = s && !sel_b;
      startB = s && sel_b;
      iR     = DW'(k);
      iG     = DW'(k + 'h40);
      iB     = DW'(k + 'h80);
      pend   = v && (sel_b ? readyB : readyA);
   endtask

   task automatic run_frame(input logic use_b, input logic stall, input int restart_cyc);
      logic          nf, rdy, vld, dn;
      logic [DW-1:0] d;
      logic [1:0]    r, c2;
      sel_b = use_b;
      k = 0; pend = 1'b0;
      nf_cnt = 0; nf_cyc = -1; first_ready = -1; done_cnt = 0; done_cyc = -1;
      rd.delete(); rrow.delete(); rcol.delete(); rcyc.delete();
      for (int c = 0; c < 64; c++) begin
         tick(stall ? (c % 2 == 0) : 1'b1, (c == 0) || (c == restart_cyc));
         nf  = use_b ? nfB    : nfA;
         rdy = use_b ? readyB : readyA;
         vld = use_b ? validB : validA;
         dn  = use_b ? doneB  : doneA;
         d   = use_b ? dataB  : dataA;
         r   = use_b ? rowB   : rowA;
         c2  = use_b ? colB   : colA;
         busy_log[c] = use_b ? busyB : busyA;
         if (nf) begin
            nf_cnt++;
            if (nf_cyc < 0) nf_cyc = c;
         end
         if (rdy && first_ready < 0) first_ready = c;
         if (vld) begin
            rd.push_back(d); rrow.push_back(int'(r));
            rcol.push_back(int'(c2)); rcyc.push_back(c);
         end
         if (dn) begin
            done_cnt++;
            done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      iValid = 1'b0;
   endtask

   task automatic test_reset;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({readyA, nfA, validA, dataA, rowA, colA, busyA, doneA} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs_a: got %h required 0",
                  {readyA, nfA, validA, dataA, rowA, colA, busyA, doneA});
      end
      tests_run++;
      if ({readyB, nfB, validB, dataB, rowB, colB, busyB, doneB} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs_b: got %h required 0",
                  {readyB, nfB, validB, dataB, rowB, colB, busyB, doneB});
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({readyA, busyA} !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got ready/busy %b required 00", {readyA, busyA});
      end
   endtask

   task automatic test_basic;
      logic [DW-1:0] exp_d [12] = '{8'h40, 8'h81, 8'h42, 8'h83, 8'h04, 8'h45, 8'h06, 8'h47,
                                    8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1'b0, 1'b0, -1);
      tests_run++;
      if (nf_cyc !== 1 || nf_cnt !== 1) begin
         tests_failed++;
         $display("FAIL basic_newframe: got cycle %0d count %0d required cycle 1 count 1", nf_cyc, nf_cnt);
      end
      tests_run++;
      if (first_ready !== nf_cyc + LD) begin
         tests_failed++;
         $display("FAIL basic_first_ready: got cycle %0d required %0d", first_ready, nf_cyc + LD);
      end
      tests_run++;
      if (rd.size() !== 12) begin
         tests_failed++;
         $display("FAIL basic_sample_count: got %0d required 12", rd.size());
      end
      for (int i = 0; i < 12 && i < rd.size(); i++) begin
         tests_run++;
         if (rd[i] !== exp_d[i] || rrow[i] !== i / W || rcol[i] !== i % W) begin
            tests_failed++;
            $display("FAIL basic_sample[%0d]: got data %h row %0d col %0d required data %h row %0d col %0d",
                     i, rd[i], rrow[i], rcol[i], exp_d[i], i / W, i % W);
         end
      end
      if (rcyc.size() == 12) begin
         tests_run++;
         if (rcyc[0] !== nf_cyc + LD + 1) begin
            tests_failed++;
            $display("FAIL basic_first_valid: got cycle %0d required %0d", rcyc[0], nf_cyc + LD + 1);
         end
         tests_run++;
         if (rcyc[4] - rcyc[3] !== HB + 1 || rcyc[8] - rcyc[7] !== HB + 1) begin
            tests_failed++;
            $display("FAIL basic_hblank_gap: got %0d,%0d required %0d", rcyc[4] - rcyc[3],
                     rcyc[8] - rcyc[7], HB + 1);
         end
      end
      tests_run++;
      if (done_cnt !== 1 || done_cyc !== 22) begin
         tests_failed++;
         $display("FAIL basic_done: got count %0d cycle %0d required count 1 cycle 22", done_cnt, done_cyc);
      end
      tests_run++;
      if (busy_log[1] !== 1'b1 || busy_log[21] !== 1'b1 || busy_log[22] !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_busy: got %b%b%b required 110", busy_log[1], busy_log[21], busy_log[22]);
      end
   endtask

   task automatic test_pattern_sweep;
      logic [DW-1:0] exp_d [12] = '{8'h80, 8'h41, 8'h82, 8'h43, 8'h44, 8'h05, 8'h46, 8'h07,
                                    8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1'b1, 1'b0, -1);
      tests_run++;
      if (rd.size() !== 12) begin
         tests_failed++;
         $display("FAIL bggr_sample_count: got %0d required 12", rd.size());
      end
      for (int i = 0; i < 12 && i < rd.size(); i++) begin
         tests_run++;
         if (rd[i] !== exp_d[i]) begin
            tests_failed++;
            $display("FAIL bggr_sample[%0d]: got %h required %h", i, rd[i], exp_d[i]);
         end
      end
      tests_run++;
      if (done_cnt !== 1) begin
         tests_failed++;
         $display("FAIL bggr_done: got count %0d required 1", done_cnt);
      end
   endtask

   task automatic test_stalls;
      logic [DW-1:0] exp_d [8] = '{8'h40, 8'h81, 8'h42, 8'h83, 8'h04, 8'h45, 8'h06, 8'h47};
      run_frame(1'b0, 1'b1, -1);
      tests_run++;
      if (rd.size() !== 12) begin
         tests_failed++;
         $display("FAIL stall_sample_count: got %0d required 12", rd.size());
      end
      for (int i = 0; i < 8 && i < rd.size(); i++) begin
         tests_run++;
         if (rd[i] !== exp_d[i] || rcol[i] !== i % W) begin
            tests_failed++;
            $display("FAIL stall_sample[%0d]: got data %h col %0d required data %h col %0d",
                     i, rd[i], rcol[i], exp_d[i], i % W);
         end
      end
      if (rcyc.size() >= 4) begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rcyc[i + 1] - rcyc[i] !== 2) begin
               tests_failed++;
               $display("FAIL stall_gap[%0d]: got %0d required 2", i, rcyc[i + 1] - rcyc[i]);
            end
         end
      end
      tests_run++;
      if (done_cnt !== 1) begin
         tests_failed++;
         $display("FAIL stall_done: got count %0d required 1", done_cnt);
      end
   endtask

   task automatic test_start_busy;
      run_frame(1'b0, 1'b0, 6);
      tests_run++;
      if (nf_cnt !== 1) begin
         tests_failed++;
         $display("FAIL busy_start_newframe: got count %0d required 1", nf_cnt);
      end
      tests_run++;
      if (rd.size() !== 12 || done_cnt !== 1 || done_cyc !== 22) begin
         tests_failed++;
         $display("FAIL busy_start_frame: got samples %0d done %0d at %0d required 12 1 22",
                  rd.size(), done_cnt, done_cyc);
      end
      if (rd.size() == 12) begin
         tests_run++;
         if (rd[5] !== 8'h45) begin
            tests_failed++;
            $display("FAIL busy_start_sample5: got %h required 45", rd[5]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic hit;
      int   dcnt;
      sel_b = 1'b0; k = 0; pend = 1'b0; hit = 1'b0; dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         tick(1'b1, c == 0);
         if (validA && rowA == 2'd1 && colA == 2'd2) begin
            hit = 1'b1;
            break;
         end
      end
      tests_run++;
      if (hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_reach: got %b required 1", hit);
      end
      #3 reset = 1'b0;
      #1;
      tests_run++;
      if ({readyA, nfA, validA, dataA, rowA, colA, busyA, doneA} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_async_clear: got %h required 0",
                  {readyA, nfA, validA, dataA, rowA, colA, busyA, doneA});
      end
      repeat (3) begin
         tick(1'b1, 1'b0);
         if (doneA) dcnt++;
      end
      reset = 1'b1;
      repeat (6) begin
         tick(1'b1, 1'b0);
         if (doneA) dcnt++;
      end
      tests_run++;
      if (dcnt !== 0 || busyA !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_no_done: got done count %0d busy %b required 0 0", dcnt, busyA);
      end
      run_frame(1'b0, 1'b0, -1);
      tests_run++;
      if (nf_cnt !== 1 || rd.size() !== 12 || done_cnt !== 1) begin
         tests_failed++;
         $display("FAIL midreset_clean_frame: got nf %0d samples %0d done %0d required 1 12 1",
                  nf_cnt, rd.size(), done_cnt);
      end
      if (rd.size() == 12) begin
         tests_run++;
         if (rd[0] !== 8'h40 || rd[7] !== 8'h47) begin
            tests_failed++;
            $display("FAIL midreset_clean_data: got %h %h required 40 47", rd[0], rd[7]);
         end
      end
   endtask

`ifdef BAYER_RUNTIME_PATTERN_EN
   task automatic test_runtime_pattern;
      logic [DW-1:0] exp_d [8] = '{8'h00, 8'h41, 8'h02, 8'h43, 8'h44, 8'h85, 8'h46, 8'h87};
      patA = 2'd2;
      fork
         run_frame(1'b0, 1'b0, -1);
         begin
            repeat (9) @(posedge clk);
            #2 patA = 2'd0;
         end
      join
      tests_run++;
      if (rd.size() !== 12) begin
         tests_failed++;
         $display("FAIL runtime_sample_count: got %0d required 12", rd.size());
      end
      for (int i = 0; i < 8 && i < rd.size(); i++) begin
         tests_run++;
         if (rd[i] !== exp_d[i]) begin
            tests_failed++;
            $display("FAIL runtime_sample[%0d]: got %h required %h", i, rd[i], exp_d[i]);
         end
      end
   endtask
`endif

   initial begin
      reset  = 1'b1;
      startA = 1'b0;
      startB = 1'b0;
      iValid = 1'b0;
      iR = '0; iG = '0; iB = '0;
      k = 0; pend = 1'b0; sel_b = 1'b0;
`ifdef BAYER_RUNTIME_PATTERN_EN
      patA = 2'd0;
      patB = 2'd3;
`endif
      test_reset;
      test_basic;
      test_pattern_sweep;
      test_stalls;
      test_start_busy;
      test_reset_mid;
`ifdef BAYER_RUNTIME_PATTERN_EN
      test_runtime_pattern;
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
